// File: rtl/spi_master.sv
// Single-byte SPI master, CPOL=0, MSB first, with a programmable SCLK divider.
// Shifts tx_data out on mosi while capturing miso into rx_data, then signals
// completion with a one-cycle done/irq pulse. The SCLK half-period is latched
// when a transfer starts, so clk_div_in may change freely mid-transfer.
`timescale 1ns/1ps

module spi_master #(
  parameter logic [15:0] DEFAULT_CLK_DIV = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  tx_data,
  input  logic [15:0] clk_div_in,
  output logic [7:0]  rx_data,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        irq,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk,
  output logic        cs
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Registered state and datapath.
  state_t      state_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  tx_shift_q;
  logic [7:0]  rx_shift_q;

  // Next-state values computed combinationally.
  state_t      state_nxt;
  logic [15:0] div_nxt;
  logic [15:0] cnt_nxt;
  logic [2:0]  bit_cnt_nxt;
  logic [7:0]  tx_shift_nxt;
  logic [7:0]  rx_shift_nxt;
  logic [7:0]  rx_data_nxt;
  logic        ready_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        irq_nxt;
  logic        mosi_nxt;
  logic        sclk_nxt;
  logic        cs_nxt;

  // Last clk cycle of the current SCLK half-period (div_q is never zero).
  logic        phase_end;
  assign phase_end = (cnt_q == (div_q - 16'd1));

  // State register: every output is registered so the SPI pins are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= DEFAULT_CLK_DIV;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data    <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      mosi       <= 1'b0;
      sclk       <= 1'b0;
      cs         <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed in the previous cycle, independent of statement order.
      state_q    <= state_nxt;
      div_q      <= div_nxt;
      cnt_q      <= cnt_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      tx_shift_q <= tx_shift_nxt;
      rx_shift_q <= rx_shift_nxt;
      rx_data    <= rx_data_nxt;
      ready      <= ready_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      irq        <= irq_nxt;
      mosi       <= mosi_nxt;
      sclk       <= sclk_nxt;
      cs         <= cs_nxt;
    end
  end

  // Next-state and output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_nxt    = state_q;
    div_nxt      = div_q;
    cnt_nxt      = cnt_q;
    bit_cnt_nxt  = bit_cnt_q;
    tx_shift_nxt = tx_shift_q;
    rx_shift_nxt = rx_shift_q;
    rx_data_nxt  = rx_data;
    ready_nxt    = ready;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    irq_nxt      = 1'b0;
    mosi_nxt     = mosi;
    sclk_nxt     = sclk;
    cs_nxt       = cs;

    unique case (state_q)
      IDLE: begin
        if (start && ready) begin
          tx_shift_nxt = tx_data;
          div_nxt      = (clk_div_in == 16'd0) ? DEFAULT_CLK_DIV : clk_div_in;
          rx_shift_nxt = '0;
          cs_nxt       = 1'b0;
          mosi_nxt     = tx_data[7];
          busy_nxt     = 1'b1;
          ready_nxt    = 1'b0;
          bit_cnt_nxt  = '0;
          cnt_nxt      = '0;
          state_nxt    = LEAD;
        end
      end

      // Setup time: mosi already holds bit 7 before the first rising edge.
      LEAD: begin
        if (phase_end) begin
          sclk_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      HIGH: begin
        if (phase_end) begin
          sclk_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      // Sampling one clk after the falling edge lets a slave that changes
      // miso on that edge settle first. With div=1 the sample and the next
      // rising edge land on the same clk.
      LOW: begin
        if (cnt_q == 16'd0) begin
          rx_shift_nxt = {rx_shift_q[6:0], miso};
          // After the last bit mosi keeps bit 0 rather than shifting in junk.
          if (bit_cnt_q != 3'd7) begin
            mosi_nxt     = tx_shift_q[6];
            tx_shift_nxt = {tx_shift_q[6:0], 1'b0};
          end
        end
        if (phase_end) begin
          cnt_nxt = '0;
          if (bit_cnt_q == 3'd7) begin
            state_nxt = FINISH;
          end else begin
            bit_cnt_nxt = bit_cnt_q + 3'd1;
            sclk_nxt    = 1'b1;
            state_nxt   = HIGH;
          end
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      // rx_data and done become visible together on the following clk.
      FINISH: begin
        cs_nxt      = 1'b1;
        rx_data_nxt = rx_shift_q;
        done_nxt    = 1'b1;
        irq_nxt     = 1'b1;
        busy_nxt    = 1'b0;
        ready_nxt   = 1'b1;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master: loopback transfers, divider settings,
// start-while-busy, held start, and reset in the middle of a byte.
`timescale 1ns/1ps

module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic [15:0] clk_div_in = 16'd0;
  logic [7:0]  rx_data;
  logic        ready;
  logic        busy;
  logic        done;
  logic        irq;
  logic        miso;
  logic        mosi;
  logic        sclk;
  logic        cs;

  int vectors = 0;
  int miscompares = 0;

  // Slave model: loopback returns mosi, captured on the SCLK falling edge.
  logic loopback = 1'b1;
  logic miso_tie = 1'b0;
  logic loop_bit = 1'b0;
  assign miso = loopback ? loop_bit : miso_tie;

  always @(negedge sclk) begin
    if (!cs) loop_bit <= mosi;
  end

  always #5 clk = ~clk;

  spi_master dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tx_data    (tx_data),
    .clk_div_in (clk_div_in),
    .rx_data    (rx_data),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .irq        (irq),
    .miso       (miso),
    .mosi       (mosi),
    .sclk       (sclk),
    .cs         (cs)
  );

  // Bus monitor statistics, sampled mid-cycle; tests compare differences.
  int exp_half = 4;
  int rise_cnt = 0, fall_cnt = 0, done_cnt = 0;
  int bad_width = 0, irq_bad = 0, sclk_cs_bad = 0, mosi_zero = 0;
  int run_hi = 0, run_lo = 0;
  bit in_low = 0;
  logic prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (cs !== 1'b0) begin
      run_hi = 0; run_lo = 0; in_low = 0;
      if (sclk !== 1'b0) sclk_cs_bad++;
    end else begin
      if (sclk && !prev_sclk) begin
        rise_cnt++;
        if (in_low && run_lo != exp_half) bad_width++;
        run_hi = 1; in_low = 0;
      end else if (!sclk && prev_sclk) begin
        fall_cnt++;
        if (run_hi != exp_half) bad_width++;
        in_low = 1; run_lo = 1;
      end else if (sclk) begin
        run_hi++;
      end else if (in_low) begin
        run_lo++;
      end
      if (mosi === 1'b0) mosi_zero++;
    end
    if (done === 1'b1) done_cnt++;
    if (irq !== done) irq_bad++;
    prev_sclk = sclk;
  end

  // Present a one-cycle start pulse; returns at the negedge after acceptance.
  task automatic start_xfer(input logic [7:0] tx, input logic [15:0] div);
    @(negedge clk);
    tx_data = tx; clk_div_in = div; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; cycles counts negedges since the accepting posedge.
  task automatic wait_done(input int budget, input int c0, output int cycles,
                           output bit timed_out);
    cycles = c0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b expected 1", cs); end
    vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    int r0, f0, d0, w0, i0, cyc;
    bit to;
    loopback = 1'b1; exp_half = 4;
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt; w0 = bad_width; i0 = irq_bad;
    start_xfer(8'hA5, 16'd0);
    vectors++; if (cs !== 1'b0) begin miscompares++; $display("FAIL lb_cs_low: got %b expected 0", cs); end
    vectors++; if (busy !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL lb_busy: got busy=%b ready=%b expected 1/0", busy, ready); end
    vectors++; if (mosi !== 1'b1) begin miscompares++; $display("FAIL lb_first_mosi: got %b expected 1", mosi); end
    wait_done(200, 1, cyc, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL lb_timeout: got %0d cycles expected done", cyc); end
    vectors++; if (cyc !== 70) begin miscompares++; $display("FAIL lb_latency: got %0d expected 70", cyc); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL lb_rx: got %h expected a5", rx_data); end
    vectors++; if (cs !== 1'b1 || ready !== 1'b1) begin miscompares++; $display("FAIL lb_end_idle: got cs=%b ready=%b expected 1/1", cs, ready); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL lb_done_width: got %b expected 0", done); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL lb_rx_hold: got %h expected a5", rx_data); end
    vectors++; if (rise_cnt - r0 !== 8) begin miscompares++; $display("FAIL lb_rises: got %0d expected 8", rise_cnt - r0); end
    vectors++; if (fall_cnt - f0 !== 8) begin miscompares++; $display("FAIL lb_falls: got %0d expected 8", fall_cnt - f0); end
    vectors++; if (bad_width - w0 !== 0) begin miscompares++; $display("FAIL lb_width: got %0d bad half-periods expected 0", bad_width - w0); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL lb_done_cnt: got %0d expected 1", done_cnt - d0); end
    vectors++; if (irq_bad - i0 !== 0) begin miscompares++; $display("FAIL lb_irq: got %0d irq/done disagreements expected 0", irq_bad - i0); end
  endtask

  task automatic test_back_to_back();
    int d0, i0, cyc;
    bit to;
    d0 = done_cnt; i0 = irq_bad;
    repeat (5) @(negedge clk);
    start_xfer(8'h3C, 16'd0);
    wait_done(200, 1, cyc, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout: got %0d cycles expected done", cyc); end
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL b2b_rx: got %h expected 3c", rx_data); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL b2b_irq: got %b expected 1", irq); end
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL b2b_irq_width: got %b expected 0", irq); end
    vectors++; if (done_cnt - d0 !== 1 || irq_bad - i0 !== 0) begin miscompares++; $display("FAIL b2b_pulses: got done=%0d irqbad=%0d expected 1/0", done_cnt - d0, irq_bad - i0); end
  endtask

  task automatic test_div2();
    int r0, w0, z0, cyc;
    bit to;
    loopback = 1'b0; miso_tie = 1'b0; exp_half = 2;
    r0 = rise_cnt; w0 = bad_width; z0 = mosi_zero;
    start_xfer(8'hFF, 16'd2);
    wait_done(200, 1, cyc, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL div2_timeout: got %0d cycles expected done", cyc); end
    vectors++; if (cyc !== 36) begin miscompares++; $display("FAIL div2_latency: got %0d expected 36", cyc); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL div2_rx: got %h expected 00", rx_data); end
    vectors++; if (rise_cnt - r0 !== 8) begin miscompares++; $display("FAIL div2_rises: got %0d expected 8", rise_cnt - r0); end
    vectors++; if (bad_width - w0 !== 0) begin miscompares++; $display("FAIL div2_width: got %0d bad half-periods expected 0", bad_width - w0); end
    vectors++; if (mosi_zero - z0 !== 0) begin miscompares++; $display("FAIL div2_mosi: got %0d low samples expected 0", mosi_zero - z0); end
    @(negedge clk);
    loopback = 1'b1;
  endtask

  task automatic test_busy_start();
    int r0, w0, d0, cyc;
    bit to;
    exp_half = 4;
    r0 = rise_cnt; w0 = bad_width; d0 = done_cnt;
    start_xfer(8'h5A, 16'd0);
    repeat (20) @(negedge clk);
    tx_data = 8'h00; clk_div_in = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || cs !== 1'b0) begin miscompares++; $display("FAIL busy_still: got busy=%b cs=%b expected 1/0", busy, cs); end
    wait_done(200, 22, cyc, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL busy_timeout: got %0d cycles expected done", cyc); end
    vectors++; if (cyc !== 70) begin miscompares++; $display("FAIL busy_latency: got %0d expected 70", cyc); end
    vectors++; if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL busy_rx: got %h expected 5a", rx_data); end
    repeat (20) @(negedge clk);
    vectors++; if (rise_cnt - r0 !== 8) begin miscompares++; $display("FAIL busy_rises: got %0d expected 8", rise_cnt - r0); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL busy_done_cnt: got %0d expected 1", done_cnt - d0); end
    vectors++; if (bad_width - w0 !== 0) begin miscompares++; $display("FAIL busy_width: got %0d bad half-periods expected 0", bad_width - w0); end
    vectors++; if (cs !== 1'b1 || ready !== 1'b1) begin miscompares++; $display("FAIL busy_idle: got cs=%b ready=%b expected 1/1", cs, ready); end
  endtask

  task automatic test_held_start();
    int w0, cyc;
    bit to;
    exp_half = 1;
    w0 = bad_width;
    @(negedge clk);
    tx_data = 8'hC3; clk_div_in = 16'd1; start = 1'b1;
    @(negedge clk);
    wait_done(100, 1, cyc, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL held_timeout1: got %0d cycles expected done", cyc); end
    vectors++; if (cyc !== 19) begin miscompares++; $display("FAIL held_latency1: got %0d expected 19", cyc); end
    vectors++; if (rx_data !== 8'hC3) begin miscompares++; $display("FAIL held_rx1: got %h expected c3", rx_data); end
    tx_data = 8'h69;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (cs !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL held_restart: got cs=%b busy=%b done=%b expected 0/1/0", cs, busy, done); end
    wait_done(100, 1, cyc, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL held_timeout2: got %0d cycles expected done", cyc); end
    vectors++; if (cyc !== 19) begin miscompares++; $display("FAIL held_latency2: got %0d expected 19", cyc); end
    vectors++; if (rx_data !== 8'h69) begin miscompares++; $display("FAIL held_rx2: got %h expected 69", rx_data); end
    vectors++; if (bad_width - w0 !== 0) begin miscompares++; $display("FAIL held_width: got %0d bad half-periods expected 0", bad_width - w0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0, r0, s0, cyc;
    bit to;
    exp_half = 4;
    d0 = done_cnt;
    start_xfer(8'hF0, 16'd0);
    repeat (29) @(negedge clk);
    vectors++; if (sclk !== 1'b1 || cs !== 1'b0) begin miscompares++; $display("FAIL rmid_pre: got sclk=%b cs=%b expected 1/0", sclk, cs); end
    reset = 1'b1;
    #1;
    vectors++; if (cs !== 1'b1 || sclk !== 1'b0) begin miscompares++; $display("FAIL rmid_abort: got cs=%b sclk=%b expected 1/0", cs, sclk); end
    vectors++; if (busy !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL rmid_flags: got busy=%b ready=%b expected 0/1", busy, ready); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rmid_rx: got %h expected 00", rx_data); end
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL rmid_no_done: got %0d done pulses expected 0", done_cnt - d0); end
    r0 = rise_cnt; s0 = sclk_cs_bad;
    start_xfer(8'h96, 16'd0);
    wait_done(200, 1, cyc, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rmid_timeout: got %0d cycles expected done", cyc); end
    vectors++; if (rx_data !== 8'h96) begin miscompares++; $display("FAIL rmid_rx_after: got %h expected 96", rx_data); end
    vectors++; if (rise_cnt - r0 !== 8) begin miscompares++; $display("FAIL rmid_rises: got %0d expected 8", rise_cnt - r0); end
    vectors++; if (sclk_cs_bad - s0 !== 0) begin miscompares++; $display("FAIL rmid_sclk_idle: got %0d samples with sclk high expected 0", sclk_cs_bad - s0); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_div2();
    test_busy_start();
    test_held_start();
    test_reset_mid();
    vectors++; if (sclk_cs_bad !== 0) begin miscompares++; $display("FAIL sclk_while_cs_high: got %0d samples expected 0", sclk_cs_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
